// File: rtl/cheri_tbre_ctrl.sv
// cheri_tbre_ctrl: tag-based revocation engine sweep controller.
// Walks [start, end) in 8-byte steps. Each word gets a capability load, then
// the controller waits for a revocation verdict. A revoked word gets a
// tag-clear store. Includes stop handling and an LSU grant watchdog.
// Optional macro TBRE_STATS_EN adds the revoked_cnt_o counter output.
module cheri_tbre_ctrl #(
    parameter int unsigned GntTimeout = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [31:0] start_addr_i,
    input  logic [31:0] end_addr_i,
    output logic        tbre_lsu_req_o,
    output logic        tbre_lsu_we_o,
    output logic [31:0] tbre_lsu_addr_o,
    input  logic        lsu_tbre_gnt_i,
    input  logic        lsu_tbre_resp_valid_i,
    input  logic        lsu_tbre_resp_err_i,
    input  logic        tbre_trvk_en_i,
    input  logic        tbre_trvk_clrtag_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        abort_o,
    output logic [31:0] cur_addr_o
`ifdef TBRE_STATS_EN
    ,
    output logic [31:0] revoked_cnt_o
`endif
);

    typedef enum logic [2:0] {
        IDLE, LD_REQ, LD_WAIT, CHK_WAIT, ST_REQ, ST_WAIT, NEXT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cur_addr_q, cur_addr_d;
    logic [31:0] end_addr_q, end_addr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        abort_q, abort_d;
    logic        stop_pend_q, stop_pend_d;
    logic        ld_err_q, ld_err_d;
    logic [7:0]  gnt_cnt_q, gnt_cnt_d;
`ifdef TBRE_STATS_EN
    logic [31:0] rev_cnt_q, rev_cnt_d;
`endif

    logic [31:0] start_al, end_al, next_addr;
    logic        gnt_expired;

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            end_addr_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
            stop_pend_q <= 1'b0;
            ld_err_q    <= 1'b0;
            gnt_cnt_q   <= '0;
`ifdef TBRE_STATS_EN
            rev_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            end_addr_q  <= end_addr_d;
            done_q      <= done_d;
            err_q       <= err_d;
            abort_q     <= abort_d;
            stop_pend_q <= stop_pend_d;
            ld_err_q    <= ld_err_d;
            gnt_cnt_q   <= gnt_cnt_d;
`ifdef TBRE_STATS_EN
            rev_cnt_q   <= rev_cnt_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        end_addr_d  = end_addr_q;
        done_d      = done_q;
        err_d       = err_q;
        abort_d     = abort_q;
        stop_pend_d = stop_pend_q;
        ld_err_d    = ld_err_q;
        gnt_cnt_d   = gnt_cnt_q;
`ifdef TBRE_STATS_EN
        rev_cnt_d   = rev_cnt_q;
`endif
        // Masking keeps the full input word in use while discarding bits [2:0]
        start_al    = start_addr_i & ~32'h7;
        end_al      = end_addr_i & ~32'h7;
        next_addr   = cur_addr_q + 32'd8;
        gnt_expired = (gnt_cnt_q == 8'(GntTimeout - 1));

        if (stop_i && state_q != IDLE) stop_pend_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    end_addr_d  = end_al;
                    err_d       = 1'b0;
                    abort_d     = 1'b0;
                    stop_pend_d = 1'b0;
                    gnt_cnt_d   = '0;
`ifdef TBRE_STATS_EN
                    rev_cnt_d   = '0;
`endif
                    if (start_al >= end_al) begin
                        done_d = 1'b1;
                    end else begin
                        done_d     = 1'b0;
                        cur_addr_d = start_al;
                        state_d    = LD_REQ;
                    end
                end
            end
            LD_REQ, ST_REQ: begin
                if (lsu_tbre_gnt_i) begin
                    gnt_cnt_d = '0;
                    state_d   = (state_q == LD_REQ) ? LD_WAIT : ST_WAIT;
                end else if (gnt_expired) begin
                    gnt_cnt_d   = '0;
                    err_d       = 1'b1;
                    abort_d     = 1'b1;
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    gnt_cnt_d = gnt_cnt_q + 8'd1;
                end
            end
            LD_WAIT: begin
                if (lsu_tbre_resp_valid_i) begin
                    ld_err_d = lsu_tbre_resp_err_i;
                    if (lsu_tbre_resp_err_i) err_d = 1'b1;
                    state_d = CHK_WAIT;
                end
            end
            CHK_WAIT: begin
                if (tbre_trvk_en_i) begin
                    state_d = (tbre_trvk_clrtag_i && !ld_err_q) ? ST_REQ : NEXT;
                end
            end
            ST_WAIT: begin
                if (lsu_tbre_resp_valid_i) begin
                    if (lsu_tbre_resp_err_i) err_d = 1'b1;
`ifdef TBRE_STATS_EN
                    else if (rev_cnt_q != '1) rev_cnt_d = rev_cnt_q + 32'd1;
`endif
                    state_d = NEXT;
                end
            end
            NEXT: begin
                cur_addr_d = next_addr;
                // A stop arriving in this very cycle is honoured here as well
                if (stop_pend_q || stop_i) begin
                    done_d      = 1'b1;
                    abort_d     = 1'b1;
                    stop_pend_d = 1'b0;
                    state_d     = IDLE;
                end else if (next_addr == '0 || next_addr >= end_addr_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = LD_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state and registers
    always_comb begin
        tbre_lsu_req_o  = (state_q == LD_REQ) || (state_q == ST_REQ);
        tbre_lsu_we_o   = (state_q == ST_REQ);
        tbre_lsu_addr_o = cur_addr_q;
        busy_o          = (state_q != IDLE);
        done_o          = done_q;
        err_o           = err_q;
        abort_o         = abort_q;
        cur_addr_o      = cur_addr_q;
`ifdef TBRE_STATS_EN
        revoked_cnt_o   = rev_cnt_q;
`endif
    end

endmodule

// File: tb/tb_cheri_tbre_ctrl.sv
// Directed testbench for cheri_tbre_ctrl. Inputs change and outputs are
// sampled on the falling clock edge. The DUT captures on the rising edge.
module tb_cheri_tbre_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni, start_i, stop_i;
    logic [31:0] start_addr_i, end_addr_i;
    logic        req, we;
    logic [31:0] addr;
    logic        gnt, resp_valid, resp_err, trvk_en, trvk_clrtag;
    logic        busy, done, err, abort;
    logic [31:0] cur_addr;
`ifdef TBRE_STATS_EN
    logic [31:0] revoked_cnt;
`endif

    int n_asrt = 0;
    int n_fail = 0;
    int n_ld   = 0;
    int n_st   = 0;

    always #5 clk = ~clk;

    cheri_tbre_ctrl #(.GntTimeout(255)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_ni),
        .start_i               (start_i),
        .stop_i                (stop_i),
        .start_addr_i          (start_addr_i),
        .end_addr_i            (end_addr_i),
        .tbre_lsu_req_o        (req),
        .tbre_lsu_we_o         (we),
        .tbre_lsu_addr_o       (addr),
        .lsu_tbre_gnt_i        (gnt),
        .lsu_tbre_resp_valid_i (resp_valid),
        .lsu_tbre_resp_err_i   (resp_err),
        .tbre_trvk_en_i        (trvk_en),
        .tbre_trvk_clrtag_i    (trvk_clrtag),
        .busy_o                (busy),
        .done_o                (done),
        .err_o                 (err),
        .abort_o               (abort),
        .cur_addr_o            (cur_addr)
`ifdef TBRE_STATS_EN
        ,
        .revoked_cnt_o         (revoked_cnt)
`endif
    );

    // Count granted LSU transactions by kind
    always @(posedge clk) begin
        if (req && gnt) begin
            if (we) n_st++;
            else    n_ld++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, req, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic start_sweep(input logic [31:0] s, input logic [31:0] e);
        start_addr_i = s;
        end_addr_i   = e;
        start_i      = 1'b1;
        @(negedge clk);
        start_i      = 1'b0;
    endtask

    // Serve one load: optional grant delay, optional stop pulse in LD_WAIT,
    // response, then a verdict three cycles after the response
    task automatic serve_load(input logic [31:0] a, input logic rerr, input logic clr,
                              input int unsigned dly, input logic stp);
        wait_req("ld_req");
        chk("ld_we", we, 0);
        chk("ld_addr", addr, a);
        for (int unsigned i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("ld_hold", {req, addr[30:0]}, {1'b1, a[30:0]});
        end
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        chk("ld_wait_noreq", req, 0);
        stop_i = stp;
        @(negedge clk);
        stop_i     = 1'b0;
        resp_valid = 1'b1;
        resp_err   = rerr;
        @(negedge clk);
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        if (rerr) chk("ld_err_sticky", err, 1);
        repeat (2) @(negedge clk);
        trvk_en     = 1'b1;
        trvk_clrtag = clr;
        @(negedge clk);
        trvk_en     = 1'b0;
        trvk_clrtag = 1'b0;
    endtask

    task automatic serve_store(input logic [31:0] a);
        wait_req("st_req");
        chk("st_we", we, 1);
        chk("st_addr", addr, a);
        gnt = 1'b1;
        @(negedge clk);
        gnt        = 1'b0;
        resp_valid = 1'b1;
        @(negedge clk);
        resp_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        int base_ld;
        int base_st;
        start_i = 0; stop_i = 0; start_addr_i = 0; end_addr_i = 0;
        gnt = 0; resp_valid = 0; resp_err = 0; trvk_en = 0; trvk_clrtag = 0;
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_abort", abort, 0);
        chk("rst_req", req, 0);
        chk("rst_cur_addr", cur_addr, 0);
        rst_ni = 1'b1;
        @(negedge clk);

        // Three-word sweep, nothing revoked; a stray start mid-sweep is ignored
        base_ld = n_ld; base_st = n_st;
        start_sweep(32'h8000_0000, 32'h8000_0018);
        chk("s1_busy", busy, 1);
        chk("s1_cur", cur_addr, 32'h8000_0000);
        serve_load(32'h8000_0000, 0, 0, 3, 0);
        start_addr_i = 32'h0;
        start_i      = 1'b1;
        @(negedge clk);
        start_i      = 1'b0;
        serve_load(32'h8000_0008, 0, 0, 0, 0);
        serve_load(32'h8000_0010, 0, 0, 0, 0);
        wait_idle("s1_idle");
        chk("s1_done", done, 1);
        chk("s1_err", err, 0);
        chk("s1_abort", abort, 0);
        chk("s1_cur_end", cur_addr, 32'h8000_0018);
        chk("s1_loads", n_ld - base_ld, 3);
        chk("s1_stores", n_st - base_st, 0);

        // Same range, word 0x..08 revoked
        base_ld = n_ld; base_st = n_st;
        start_sweep(32'h8000_0000, 32'h8000_0018);
        chk("s2_done_clr", done, 0);
        serve_load(32'h8000_0000, 0, 0, 0, 0);
        serve_load(32'h8000_0008, 0, 1, 0, 0);
        serve_store(32'h8000_0008);
        serve_load(32'h8000_0010, 0, 0, 0, 0);
        wait_idle("s2_idle");
        chk("s2_done", done, 1);
        chk("s2_loads", n_ld - base_ld, 3);
        chk("s2_stores", n_st - base_st, 1);
`ifdef TBRE_STATS_EN
        chk("s2_revoked", revoked_cnt, 1);
`endif

        // Empty range after a fresh reset
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        base_ld = n_ld;
        start_sweep(32'h100, 32'h100);
        chk("s3_done", done, 1);
        chk("s3_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("s3_busy_later", busy, 0);
        chk("s3_loads", n_ld - base_ld, 0);

        // Stop during the second word's LD_WAIT; its store still completes
        base_ld = n_ld; base_st = n_st;
        start_sweep(32'h1000, 32'h1020);
        serve_load(32'h1000, 0, 0, 0, 0);
        serve_load(32'h1008, 0, 1, 0, 1);
        serve_store(32'h1008);
        wait_idle("s4_idle");
        chk("s4_done", done, 1);
        chk("s4_abort", abort, 1);
        chk("s4_err", err, 0);
        chk("s4_loads", n_ld - base_ld, 2);
        chk("s4_stores", n_st - base_st, 1);
        chk("s4_cur", cur_addr, 32'h1010);

        // Grant watchdog: request dropped after exactly 255 cycles
        start_sweep(32'h2000, 32'h2010);
        wait_req("s5_req");
        cnt = 0;
        while (req === 1'b1 && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        chk("s5_req_cycles", cnt, 255);
        chk("s5_busy", busy, 0);
        chk("s5_err", err, 1);
        chk("s5_abort", abort, 1);
        chk("s5_done", done, 1);

        // Load error on the second word: no store, sweep continues
        base_ld = n_ld; base_st = n_st;
        start_sweep(32'h3000, 32'h3018);
        chk("s6_err_clr", err, 0);
        chk("s6_abort_clr", abort, 0);
        serve_load(32'h3000, 0, 0, 0, 0);
        serve_load(32'h3008, 1, 1, 0, 0);
        serve_load(32'h3010, 0, 0, 0, 0);
        wait_idle("s6_idle");
        chk("s6_err", err, 1);
        chk("s6_abort", abort, 0);
        chk("s6_done", done, 1);
        chk("s6_loads", n_ld - base_ld, 3);
        chk("s6_stores", n_st - base_st, 0);

        // Asynchronous reset while a tag-clear store is requested
        start_sweep(32'h4000, 32'h4010);
        serve_load(32'h4000, 0, 1, 0, 0);
        wait_req("s7_st_req");
        chk("s7_we", we, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("s7_req", req, 0);
        chk("s7_we_rst", we, 0);
        chk("s7_busy", busy, 0);
        chk("s7_done", done, 0);
        chk("s7_cur", cur_addr, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req !== 1'b0) cnt++;
        end
        chk("s7_no_req", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/cheri_tbre_ctrl.md
CHERI_TBRE_CTRL -- requirements
Module: cheri_tbre_ctrl

Interface
REQ-001 Parameter GntTimeout, default 255: max consecutive cycles a request waits for grant before abort; legal range 1..255.
REQ-002 clk_i  input  1  single clock, rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  one-cycle pulse; begins a sweep when idle.
REQ-005 stop_i  input  1  one-cycle pulse; requests early termination.
REQ-006 start_addr_i / end_addr_i  input  32 each  sweep range [start, end); bits [2:0] ignored; sampled on accepted start_i.
REQ-007 tbre_lsu_req_o  output  1  LSU request valid.
REQ-008 tbre_lsu_we_o  output  1  0 = capability load; 1 = tag-clear-only store, no data.
REQ-009 tbre_lsu_addr_o  output  32  request address, 8-byte aligned.
REQ-010 lsu_tbre_gnt_i  input  1  LSU accepts the request this cycle.
REQ-011 lsu_tbre_resp_valid_i / lsu_tbre_resp_err_i  input  1 each  response strobe and error.
REQ-012 tbre_trvk_en_i / tbre_trvk_clrtag_i  input  1 each  revocation-check result strobe and verdict.
REQ-013 busy_o, done_o, err_o, abort_o  output  1 each  status flags.
REQ-014 cur_addr_o  output  32  address currently being processed.

Function
REQ-015 FSM states SHALL be IDLE, LD_REQ, LD_WAIT, CHK_WAIT, ST_REQ, ST_WAIT, NEXT.
REQ-016 IDLE + start_i: capture the range; go to NEXT-equivalent check: start >= end -> stay IDLE and set done_o; else go to LD_REQ with cur_addr_o = start; clear done_o/err_o/abort_o.
REQ-017 start_i outside IDLE SHALL be ignored.
REQ-018 LD_REQ: req_o=1, we_o=0, addr_o=cur_addr; req_o and addr_o held stable until gnt; on gnt go to LD_WAIT.
REQ-019 LD_WAIT: on resp_valid go to CHK_WAIT; resp_err sets err_o (sticky).
REQ-020 CHK_WAIT: wait for tbre_trvk_en_i (nominally 3 cycles after the load response, including error responses); clrtag=1 and the load had no error -> ST_REQ; otherwise go to NEXT.
REQ-021 ST_REQ: req_o=1, we_o=1, same addr; on gnt go to ST_WAIT; ST_WAIT on resp_valid go to NEXT; a store error sets err_o.
REQ-022 NEXT: cur_addr += 8 (32-bit wrap); new cur_addr >= end or wrap to 0 -> IDLE with done_o=1; else LD_REQ.
REQ-023 At most one LSU transaction outstanding; req_o SHALL be 0 in every state except LD_REQ/ST_REQ.
REQ-024 stop_i latches a stop-pending flag; the current transaction and check complete; at the next NEXT go to IDLE with done_o=1 and abort_o=1; stop_i in IDLE is ignored.
REQ-025 Grant watchdog: counter increments each REQ cycle without gnt and clears on gnt; reaching GntTimeout drops req_o and goes to IDLE with err_o=1, abort_o=1, done_o=1.
REQ-026 busy_o = (state != IDLE); done_o/err_o/abort_o sticky until next accepted start_i.
REQ-027 Responses or trvk strobes arriving in an unexpected state SHALL be ignored.

Reset
REQ-028 On rst_ni low, asynchronously: state IDLE, every output 0, cur_addr_o 0, captured range 0, counters 0, stop-pending 0; an in-flight sweep is discarded with no further request issued.

Configuration
REQ-029 Macro TBRE_STATS_EN defined: add output revoked_cnt_o [31:0], cleared on accepted start_i, +1 per ST_WAIT response without error, saturating at 0xFFFFFFFF. Undefined: port and counter absent, all other behaviour identical.

Verification
REQ-030 start=0x8000_0000, end=0x8000_0018, all clrtag=0 -> loads at 0x..00/08/10, no stores, done_o=1, err_o=0.
REQ-031 Same range, clrtag=1 on the 0x..08 check -> tag-clear store at 0x8000_0008 only; with TBRE_STATS_EN, revoked_cnt_o=1.
REQ-032 start=end=0x100 -> no request, done_o=1 the cycle after start_i, busy_o never 1.
REQ-033 stop_i during LD_WAIT of the 2nd word -> its check and any store complete; no 3rd load; done_o=1, abort_o=1.
REQ-034 gnt_i held low 255 cycles with GntTimeout=255 -> req_o drops; err_o=1, abort_o=1; second load resp_err=1 -> err_o=1, no store, sweep continues.
REQ-035 rst_ni asserted in ST_REQ -> all outputs 0 immediately; no request after release until start_i.
